// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT sequencer and its result buffer.
package ntt_pkg;

    localparam int NTT_N  = 16;
    localparam int NTT_Q  = 7681;
    localparam int NTT_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DRAIN  = 3'd4
    } ntt_state_e;

    // Counters reach N-1 and carry one spare bit so a terminal compare never aliases.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/ntt_result_buf.sv
// N x DW result buffer: capture side writes X[k] as the array reports it,
// drain side reads asynchronously so the sequencer can register out_data.
module ntt_result_buf
    import ntt_pkg::*;
#(
    parameter int N  = NTT_N,
    parameter int DW = NTT_DW,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [N];

    // Capture write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Drain read port.
    always_comb begin
        rd_data = mem_r[rd_addr];
    end

endmodule

// File: rtl/ntt_sequencer.sv
// Sequences an N-point NTT PE array: load coefficients, sweep lanes, capture, drain.
// Optional macro NTT_SEQ_RANGE_CHECK_EN reduces coefficients >= Q and raises a sticky err.
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int N        = NTT_N,
    parameter int Q        = NTT_Q,
    parameter int DW       = NTT_DW,
    parameter int PIPE_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          coef_valid,
    output logic          coef_ready,
    input  logic [DW-1:0] coef_data,
    output logic [DW-1:0] pe_en_idx,
    output logic [DW-1:0] pe_val0,
    output logic [DW-1:0] pe_val1,
    output logic [DW-1:0] lane_out,
    input  logic [DW-1:0] pe_sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] out_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = cnt_width(N);
    localparam int AW = $clog2(N);
    localparam logic [CW-1:0] ZERO_CW = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST_CW = CW'(N - 1);
    localparam logic [DW-1:0] ZERO_DW = {DW{1'b0}};
    localparam logic [DW-1:0] ONE_DW  = {{(DW-1){1'b0}}, 1'b1};

    // The buffer bypass-free read and the capture pipe both rely on these bounds.
    if (N < 2 || PIPE_LAT < 1 || Q < 2) begin : g_bad_cfg
        $error("ntt_sequencer: requires N >= 2, PIPE_LAT >= 1, Q >= 2");
    end

    ntt_state_e    state_r;
    ntt_state_e    next_state_s;
    logic [CW-1:0] i_r, k_r, r_r;
    logic [CW-1:0] i_d_s, k_d_s, r_d_s;
    logic          beat_s;
    logic          fire_s;
    logic          cap_last_s;
    logic          coef_oor_s;
    logic [DW-1:0] coef_red_s;
    logic [DW-1:0] rd_data_s;

    logic [PIPE_LAT-1:0] cap_vld_r;
    logic [CW-1:0]       cap_idx_r [PIPE_LAT];

    logic          coef_ready_d_s;
    logic          busy_d_s;
    logic          out_valid_d_s;
    logic          done_d_s;
    logic          err_d_s;
    logic [DW-1:0] lane_out_d_s;
    logic [DW-1:0] out_data_d_s;
    logic [DW-1:0] out_idx_d_s;

    assign beat_s     = coef_valid & coef_ready;
    assign fire_s     = out_valid & out_ready;
    assign cap_last_s = cap_vld_r[PIPE_LAT-1] && (cap_idx_r[PIPE_LAT-1] == LAST_CW);

`ifdef NTT_SEQ_RANGE_CHECK_EN
    localparam logic [DW-1:0] Q_DW = DW'(Q);
    assign coef_oor_s = (coef_data >= Q_DW);
    assign coef_red_s = coef_oor_s ? (coef_data % Q_DW) : coef_data;
`else
    assign coef_oor_s = 1'b0;
    assign coef_red_s = coef_data;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_LOAD;
                else       next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (beat_s && (i_r == LAST_CW)) next_state_s = ST_STREAM;
                else                            next_state_s = ST_LOAD;
            end
            ST_STREAM: begin
                if (k_r == LAST_CW) next_state_s = ST_FLUSH;
                else                next_state_s = ST_STREAM;
            end
            ST_FLUSH: begin
                if (cap_last_s) next_state_s = ST_DRAIN;
                else            next_state_s = ST_FLUSH;
            end
            ST_DRAIN: begin
                if (fire_s && (r_r == LAST_CW)) next_state_s = ST_IDLE;
                else                            next_state_s = ST_DRAIN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Counter next values; each counter is zero outside its own state.
    always_comb begin
        i_d_s = ZERO_CW;
        k_d_s = ZERO_CW;
        r_d_s = ZERO_CW;
        if (state_r == ST_LOAD) begin
            if (beat_s) i_d_s = (i_r == LAST_CW) ? ZERO_CW : i_r + ONE_CW;
            else        i_d_s = i_r;
        end else begin
            i_d_s = ZERO_CW;
        end
        if (state_r == ST_STREAM) begin
            k_d_s = (k_r == LAST_CW) ? ZERO_CW : k_r + ONE_CW;
        end else begin
            k_d_s = ZERO_CW;
        end
        if (state_r == ST_DRAIN) begin
            if (fire_s) r_d_s = (r_r == LAST_CW) ? ZERO_CW : r_r + ONE_CW;
            else        r_d_s = r_r;
        end else begin
            r_d_s = ZERO_CW;
        end
    end

    // Output logic: registered outputs are derived from the upcoming state.
    always_comb begin
        coef_ready_d_s = (next_state_s == ST_LOAD);
        busy_d_s       = (next_state_s != ST_IDLE);
        out_valid_d_s  = (next_state_s == ST_DRAIN);
        lane_out_d_s   = (next_state_s == ST_STREAM) ? DW'(k_d_s) : ZERO_DW;
        out_idx_d_s    = (next_state_s == ST_DRAIN)  ? DW'(r_d_s) : ZERO_DW;
        out_data_d_s   = (next_state_s == ST_DRAIN)  ? rd_data_s  : ZERO_DW;
        done_d_s       = (state_r == ST_DRAIN) && fire_s && (r_r == LAST_CW);
        err_d_s        = err | (beat_s & coef_oor_s);
    end

    // PE load strobe is aligned with the accepting handshake cycle itself.
    always_comb begin
        if (beat_s) begin
            pe_en_idx = DW'(i_r) + ONE_DW;
            pe_val0   = DW'(i_r);
            pe_val1   = coef_red_s;
        end else begin
            pe_en_idx = ZERO_DW;
            pe_val0   = ZERO_DW;
            pe_val1   = ZERO_DW;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r        <= ZERO_CW;
            k_r        <= ZERO_CW;
            r_r        <= ZERO_CW;
            coef_ready <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            lane_out   <= ZERO_DW;
            out_idx    <= ZERO_DW;
            out_data   <= ZERO_DW;
        end else begin
            i_r        <= i_d_s;
            k_r        <= k_d_s;
            r_r        <= r_d_s;
            coef_ready <= coef_ready_d_s;
            busy       <= busy_d_s;
            out_valid  <= out_valid_d_s;
            done       <= done_d_s;
            err        <= err_d_s;
            lane_out   <= lane_out_d_s;
            out_idx    <= out_idx_d_s;
            out_data   <= out_data_d_s;
        end
    end

    // Capture pipe: tracks which lane index pe_sum belongs to PIPE_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_r <= {PIPE_LAT{1'b0}};
            for (int s = 0; s < PIPE_LAT; s++) begin
                cap_idx_r[s] <= ZERO_CW;
            end
        end else begin
            cap_vld_r[0] <= (state_r == ST_STREAM);
            cap_idx_r[0] <= k_r;
            for (int s = 1; s < PIPE_LAT; s++) begin
                cap_vld_r[s] <= cap_vld_r[s-1];
                cap_idx_r[s] <= cap_idx_r[s-1];
            end
        end
    end

    ntt_result_buf #(
        .N  (N),
        .DW (DW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (cap_vld_r[PIPE_LAT-1]),
        .wr_addr (cap_idx_r[PIPE_LAT-1][AW-1:0]),
        .wr_data (pe_sum),
        .rd_addr (r_d_s[AW-1:0]),
        .rd_data (rd_data_s)
    );

endmodule
